// File: rtl/pp_accumulate16_if.sv
// Operand/result bus for pp_accumulate16: operand handshake in, product handshake out,
// plus the registered FSM state for observation.
interface pp_accumulate16_if;
  // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both
  // high; the sender holds valid and data stable until that edge, ready never depends on valid.
  logic        valid_i;
  logic        ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] product_o;
  logic [1:0]  state_dbg_o;

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, busy_o, valid_o, product_o, state_dbg_o
  );

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, busy_o, valid_o, product_o, state_dbg_o
  );
endinterface

// File: rtl/pp_accumulate16.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial product per cycle.
// Macro PP_ACCUM_TRUNC_EN drops product columns below TRUNC_COL from every addend.
module pp_accumulate16 #(
  parameter int TRUNC_COL = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  pp_accumulate16_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ready;
  logic        busy;
  logic        done;
  logic        accept;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic [31:0] product_q;
  logic [15:0] pp;
  logic [31:0] term;
  logic [31:0] term_kept;
  logic [31:0] acc_next;

  if (TRUNC_COL < 0 || TRUNC_COL > 31) begin : g_trunc_col_range
    $error("pp_accumulate16: TRUNC_COL must be within 0..31");
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 4'd15) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = ready & bus.valid_i;

  assign pp   = a_q & {16{b_q[cnt]}};
  assign term = {16'b0, pp} << cnt;

`ifdef PP_ACCUM_TRUNC_EN
  localparam logic [31:0] TRUNC_MASK = 32'hFFFF_FFFF << TRUNC_COL;
  assign term_kept = term & TRUNC_MASK;
`else
  assign term_kept = term;
`endif

  assign acc_next = acc + term_kept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q <= bus.a_i;
      b_q <= bus.b_i;
      acc <= '0;
      cnt <= '0;
    end else if (state_q == RUN) begin
      acc <= acc_next;
      cnt <= cnt + 4'd1;
      // The last term is folded straight into the output register.
      if (cnt == 4'd15) product_q <= acc_next;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.busy_o      = busy;
  assign bus.valid_o     = done;
  assign bus.product_o   = product_q;
  assign bus.state_dbg_o = state_q;

endmodule

// File: tb/tb_pp_accumulate16.sv
// Directed and randomized bench for pp_accumulate16 against an arithmetic product model.
module tb_pp_accumulate16;

  localparam int TRUNC_COL = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   hs_cnt;
  int   exp_hs;
  logic [31:0] exp_q[$];
  logic [31:0] got;

  pp_accumulate16_if ifc ();

  pp_accumulate16 #(.TRUNC_COL(TRUNC_COL)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && ifc.valid_o && ifc.ready_i) hs_cnt++;
  end

  function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] sum;
`ifdef PP_ACCUM_TRUNC_EN
    sum = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) sum += (32'(a) << i) & (32'hFFFF_FFFF << TRUNC_COL);
    end
`else
    sum = 32'(a) * 32'(b);
`endif
    return sum;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                       input bit hold_ready, output logic [31:0] result);
    int cyc;
    logic [31:0] exp;
    cyc = 0;
    while (!ifc.ready_o && cyc < 40) begin
      step();
      cyc++;
    end
    chk("ready_before_accept", 32'(ifc.ready_o), 32'd1);
    ifc.valid_i = 1'b1;
    ifc.a_i     = a;
    ifc.b_i     = b;
    ifc.ready_i = hold_ready;
    exp_q.push_back(ref_product(a, b));
    step();
    ifc.valid_i = 1'b0;
    chk("busy_after_accept", 32'(ifc.busy_o), 32'd1);
    chk("ready_low_in_run", 32'(ifc.ready_o), 32'd0);
    cyc = 0;
    while (!ifc.valid_o && cyc < 40) begin
      ifc.valid_i = 1'($urandom_range(0, 1));
      ifc.a_i     = 16'($urandom);
      ifc.b_i     = 16'($urandom);
      step();
      cyc++;
    end
    ifc.valid_i = 1'b0;
    chk("latency", 32'(cyc), 32'd16);
    if (!hold_ready) begin
      for (int k = 0; k < stall; k++) begin
        ifc.valid_i = 1'($urandom_range(0, 1));
        step();
        chk("valid_held", 32'(ifc.valid_o), 32'd1);
        chk("ready_low_in_done", 32'(ifc.ready_o), 32'd0);
      end
      ifc.valid_i = 1'b0;
      ifc.ready_i = 1'b1;
    end
    result = ifc.product_o;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("product", result, exp);
    step();
    exp_hs++;
    ifc.ready_i = 1'b0;
    chk("valid_low_after_hs", 32'(ifc.valid_o), 32'd0);
    chk("ready_after_hs", 32'(ifc.ready_o), 32'd1);
    chk("product_holds_in_idle", ifc.product_o, result);
  endtask

  initial begin
    int seen;
    checks      = 0;
    errors      = 0;
    hs_cnt      = 0;
    exp_hs      = 0;
    rst_n       = 1'b0;
    ifc.valid_i = 1'b0;
    ifc.ready_i = 1'b0;
    ifc.a_i     = '0;
    ifc.b_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ifc.ready_o), 32'd1);
    chk("rst_busy", 32'(ifc.busy_o), 32'd0);
    chk("rst_valid", 32'(ifc.valid_o), 32'd0);
    chk("rst_product", ifc.product_o, 32'd0);
    rst_n = 1'b1;
    step();

    do_op(16'hFFFF, 16'hFFFF, 0, 1'b1, got);
`ifndef PP_ACCUM_TRUNC_EN
    chk("ffff_squared", got, 32'hFFFE_0001);
`endif
    do_op(16'h1234, 16'h0000, 0, 1'b0, got);
    chk("zero_multiplier", got, 32'd0);
    do_op(16'h0000, 16'hABCD, 0, 1'b0, got);
    chk("zero_multiplicand", got, 32'd0);
    do_op(16'h00FF, 16'h0100, 5, 1'b0, got);
`ifndef PP_ACCUM_TRUNC_EN
    chk("backpressure_product", got, 32'h0000_FF00);
`endif

    // Abandon an operation mid-RUN with an asynchronous reset.
    ifc.valid_i = 1'b1;
    ifc.a_i     = 16'h0003;
    ifc.b_i     = 16'h0005;
    step();
    ifc.valid_i = 1'b0;
    repeat (7) step();
    chk("busy_before_reset", 32'(ifc.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 32'(ifc.ready_o), 32'd1);
    chk("midrun_rst_busy", 32'(ifc.busy_o), 32'd0);
    chk("midrun_rst_valid", 32'(ifc.valid_o), 32'd0);
    chk("midrun_rst_product", ifc.product_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ifc.ready_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ifc.valid_o) seen++;
    end
    ifc.ready_i = 1'b0;
    chk("no_valid_after_reset", 32'(seen), 32'd0);
    do_op(16'h0003, 16'h0005, 0, 1'b0, got);
`ifndef PP_ACCUM_TRUNC_EN
    chk("three_times_five", got, 32'h0000_000F);
`endif

    for (int n = 0; n < 100; n++) begin
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), got);
    end

    chk("handshake_count", 32'(hs_cnt), 32'(exp_hs));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
